// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - request size encodings
//   - FSM state encoding
//   - default memory depth in 32-bit words
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int LSU_MEM_WORDS = 512;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling for the load/store unit.
//   size_i       : access size (byte / halfword / word)
//   unsigned_i   : 1 = zero-extend loads, 0 = sign-extend
//   lane_i       : byte offset within the word (addr[1:0])
//   rdata_i      : full memory word
//   wdata_i      : right-aligned store data
//   load_data_o  : extracted and extended load result
//   merge_data_o : rdata_i with the addressed lane replaced by store data
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (lane_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        load_data_o = rdata_i;
        case (size_i)
            SIZE_B: load_data_o = unsigned_i ? {24'd0, byte_sel}
                                             : {{24{byte_sel[7]}}, byte_sel};
            SIZE_H: load_data_o = unsigned_i ? {16'd0, half_sel}
                                             : {{16{half_sel[15]}}, half_sel};
            default: load_data_o = rdata_i;
        endcase
    end

    always_comb begin
        merge_data_o = rdata_i;
        case (size_i)
            SIZE_B:  merge_data_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
            SIZE_H:  merge_data_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-addressed memory with
// asynchronous read and a full-word synchronous write enable. Sub-word stores
// are done as read-modify-write; bad requests are answered with an error and
// never reach memory.
//   clk_i, rst_ni             : clock, async active-low reset
//   req_*                     : request handshake from the core
//   rsp_valid_o/rdata_o/err_o : one-cycle response pulse
//   mem_*                     : memory port (mem_rdata_i is combinational)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request; checks it for errors on acceptance
// ACCESS | memory word addressed; load extract, word write or RMW read
// MERGE  | write back the word with the store lane replaced
// RESP   | response pulse to the core
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_wen_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] result_q, result_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;

    logic        accept;
    logic        req_err;
    logic        in_mem_phase;
    logic        word_store;
    logic [31:0] word_addr;
    logic [31:0] align_rdata;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign req_ready_o  = (state_q == ST_IDLE);
    assign accept       = req_valid_i & req_ready_o;
    assign in_mem_phase = (state_q == ST_ACCESS) || (state_q == ST_MERGE);
    assign word_store   = we_q && (size_q == SIZE_W);
    assign word_addr    = {addr_q[31:2], 2'b00};

    always_comb begin
        req_err = 1'b0;
        if (req_size_i == 2'd3)
            req_err = 1'b1;
        if ((req_size_i == SIZE_H) && req_addr_i[0])
            req_err = 1'b1;
        if ((req_size_i == SIZE_W) && (req_addr_i[1:0] != 2'b00))
            req_err = 1'b1;
        if (req_addr_i[31:2] >= 30'(MEM_WORDS))
            req_err = 1'b1;
    end

    // One aligner serves both the load path (live memory data in ACCESS) and
    // the store merge (captured word in MERGE).
    assign align_rdata = (state_q == ST_MERGE) ? merge_q : mem_rdata_i;

    lsu_align u_align (
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .lane_i       (addr_q[1:0]),
        .rdata_i      (align_rdata),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        result_d   = result_q;
        merge_d    = merge_q;
        size_d     = size_q;
        we_d       = we_q;
        uns_d      = uns_q;
        err_d      = err_q;
        mem_addr_d = in_mem_phase ? word_addr : mem_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    size_d   = req_size_i;
                    we_d     = req_we_i;
                    uns_d    = req_unsigned_i;
                    err_d    = req_err;
                    result_d = 32'd0;
                    state_d  = req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    result_d = load_data;
                    state_d  = ST_RESP;
                end else if (size_q == SIZE_W) begin
                    state_d  = ST_RESP;
                end else begin
                    merge_d  = mem_rdata_i;
                    state_d  = ST_MERGE;
                end
            end
            ST_MERGE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            result_q   <= 32'd0;
            merge_q    <= 32'd0;
            mem_addr_q <= 32'd0;
            size_q     <= 2'd0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            result_q   <= result_d;
            merge_q    <= merge_d;
            mem_addr_q <= mem_addr_d;
            size_q     <= size_d;
            we_q       <= we_d;
            uns_q      <= uns_d;
            err_q      <= err_d;
        end
    end

    // Write enable comes straight from the state register so a reset in
    // MERGE kills the pending write without waiting for a clock.
    assign mem_wen_o   = ((state_q == ST_ACCESS) && word_store) || (state_q == ST_MERGE);
    assign mem_addr_o  = in_mem_phase ? word_addr : mem_addr_q;
    assign mem_wdata_o = (state_q == ST_MERGE)                  ? merge_data :
                         ((state_q == ST_ACCESS) && word_store) ? wdata_q    : 32'd0;

    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_err_o   = rsp_valid_o && err_q;
    assign rsp_rdata_o = (rsp_valid_o && !we_q && !err_q) ? result_q : 32'd0;

endmodule
